// File: rtl/full_adder_core.sv
// full_adder_core: registered ripple-carry adder built from a chain of 1-bit
// full-adder cells. {co, so} = a + b + ci, presented one clock after a valid
// input. ovf flags two's-complement overflow (carry into MSB ^ carry out).

// Single-bit full-adder cell; the leaf of the ripple chain.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module full_adder_core #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] so,
    output logic             co,
    output logic             ovf,
    output logic             out_valid
);
    // c[i] is the carry into cell i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = ci;

    // One cell per bit; carry ripples combinationally within the cycle.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Output register: reset wins; otherwise capture only on a valid input so
    // that results hold (and garbage on idle inputs never reaches the outputs).
    always_ff @(posedge clk) begin
        if (rst) begin
            so        <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                so  <= s;
                co  <= c[WIDTH];
                ovf <= c[WIDTH] ^ c[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core: drives a WIDTH=1 and a WIDTH=8 instance side by side and
// checks every cycle against an arithmetic reference model (unsigned sum for
// so/co, signed range test for ovf).
module tb_full_adder_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       v1, a1, b1, c1;
    logic [0:0] so1;
    logic       co1, ov1, ov1_vld;
    logic       v8, c8;
    logic [7:0] a8, b8, so8;
    logic       co8, ov8, ov8_vld;

    int n_vec = 0;
    int n_err = 0;

    // Expected registered state of each instance.
    longint e1_so, e8_so;
    bit     e1_co, e1_ov, e1_vld, e8_co, e8_ov, e8_vld;

    always #5 clk = ~clk;

    full_adder_core #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .ci(c1),
        .so(so1), .co(co1), .ovf(ov1), .out_valid(ov1_vld)
    );

    full_adder_core #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .ci(c8),
        .so(so8), .co(co8), .ovf(ov8), .out_valid(ov8_vld)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition; overflow when the signed sum leaves
    // the representable two's-complement range of w bits.
    function automatic void ref_add(input int w, input longint x, input longint y,
                                    input bit c, output longint s, output bit cout,
                                    output bit ov);
        longint m, full, sx, sy, ss;
        m    = longint'(1) << w;
        full = x + y + longint'(c);
        s    = full % m;
        cout = (full >= m);
        sx   = (x >= m / 2) ? x - m : x;
        sy   = (y >= m / 2) ? y - m : y;
        ss   = sx + sy + longint'(c);
        ov   = (ss < -(m / 2)) || (ss > (m / 2) - 1);
    endfunction

    // Apply one cycle of stimulus to both instances, advance the model, check.
    task automatic cyc(input bit r, input bit va, input bit xa, input bit ya, input bit ca,
                       input bit vb, input logic [7:0] xb, input logic [7:0] yb, input bit cb);
        longint s;
        bit     co, ov;
        rst = r; v1 = va; a1 = xa; b1 = ya; c1 = ca;
        v8 = vb; a8 = xb; b8 = yb; c8 = cb;
        @(posedge clk);
        #1;
        if (r) begin
            e1_so = 0; e1_co = 0; e1_ov = 0; e1_vld = 0;
            e8_so = 0; e8_co = 0; e8_ov = 0; e8_vld = 0;
        end else begin
            e1_vld = va;
            e8_vld = vb;
            if (va) begin
                ref_add(1, longint'(xa), longint'(ya), ca, s, co, ov);
                e1_so = s; e1_co = co; e1_ov = ov;
            end
            if (vb) begin
                ref_add(8, longint'(xb), longint'(yb), cb, s, co, ov);
                e8_so = s; e8_co = co; e8_ov = ov;
            end
        end
        chk("w1_so",  longint'(so1),     e1_so);
        chk("w1_co",  longint'(co1),     longint'(e1_co));
        chk("w1_ovf", longint'(ov1),     longint'(e1_ov));
        chk("w1_vld", longint'(ov1_vld), longint'(e1_vld));
        chk("w8_so",  longint'(so8),     e8_so);
        chk("w8_co",  longint'(co8),     longint'(e8_co));
        chk("w8_ovf", longint'(ov8),     longint'(e8_ov));
        chk("w8_vld", longint'(ov8_vld), longint'(e8_vld));
    endtask

    initial begin
        rst = 1'b1; v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        v8 = 0; a8 = 0; b8 = 0; c8 = 0;

        // Reset state.
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);

        // WIDTH=1 truth table with ci=0 then ci=1, back to back.
        for (int ci = 0; ci < 2; ci++)
            for (int p = 0; p < 4; p++)
                cyc(0, 1, bit'(p & 1), bit'(p >> 1), bit'(ci), 0, 8'h00, 8'h00, 0);

        // Directed checks against the known results as well.
        cyc(0, 1, 1, 1, 1, 1, 8'hFF, 8'h01, 0);
        chk("w1_111_so", longint'(so1), 1);
        chk("w1_111_co", longint'(co1), 1);
        chk("w8_ff01_so", longint'(so8), 'h00);
        chk("w8_ff01_co", longint'(co8), 1);
        chk("w8_ff01_ovf", longint'(ov8), 0);
        cyc(0, 1, 0, 0, 0, 1, 8'h7F, 8'h01, 0);
        chk("w8_7f01_so", longint'(so8), 'h80);
        chk("w8_7f01_co", longint'(co8), 0);
        chk("w8_7f01_ovf", longint'(ov8), 1);

        // Reset beats a simultaneous valid input; next valid result one cycle later.
        cyc(1, 1, 1, 1, 0, 1, 8'h01, 8'h01, 0);
        chk("rst_so", longint'(so8), 0);
        chk("rst_vld", longint'(ov8_vld), 0);
        cyc(0, 1, 1, 0, 0, 1, 8'h03, 8'h04, 0);
        chk("post_rst_so", longint'(so8), 'h07);
        chk("post_rst_vld", longint'(ov8_vld), 1);

        // Hold: idle cycles with random operands keep the last result.
        for (int i = 0; i < 4; i++)
            cyc(0, 0, bit'($urandom), bit'($urandom), bit'($urandom),
                0, 8'($urandom), 8'($urandom), bit'($urandom));
        chk("hold_so", longint'(so8), 'h07);

        // Random sweep, mostly valid, with occasional idle and reset cycles.
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) != 0), bit'($urandom), bit'($urandom), bit'($urandom),
                ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), bit'($urandom));

        // Corner operands for the 8-bit instance.
        cyc(0, 1, 0, 0, 1, 1, 8'hFF, 8'hFF, 1);
        cyc(0, 1, 1, 1, 0, 1, 8'h80, 8'h80, 0);
        cyc(0, 1, 1, 0, 1, 1, 8'h00, 8'h00, 0);
        cyc(0, 1, 0, 1, 1, 1, 8'h7F, 8'h00, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
